// File: rtl/serial_addsub_pkg.sv
// Shared types and constant helpers for the digit-serial adder/subtractor.
// Saturation constants are used only when SERIAL_ADDSUB_SAT_EN is defined.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Results are 64 bits wide; callers keep the low WIDTH bits.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow on the most significant digit.
module serial_digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor, LSB first, valid/ready on both sides.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1,
  parameter int unsigned CNT_W = ($clog2(WIDTH / DIGIT) > 0) ? $clog2(WIDTH / DIGIT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);

  if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;
  logic             dig_cmsb;
  logic             last_digit;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] sum_shift;

  serial_digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout),
    .c_msb(dig_cmsb)
  );

  assign last_digit = (cnt_q == CNT_W'(NDIG - 1));
  assign dig_ext    = WIDTH'(dig_s);
  // New digit enters at the top; after NDIG steps the first digit sits at bit 0.
  assign sum_shift  = (sum_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [63:0] SatMaxW = sat_max(WIDTH);
  localparam logic [63:0] SatMinW = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SatMax = SatMaxW[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SatMin = SatMinW[WIDTH-1:0];
  logic a_sign;
  // On the last digit the original A sign bit is the top bit of the remaining digit.
  assign a_sign = a_q[DIGIT-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d   = sum_shift;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
`ifdef SERIAL_ADDSUB_SAT_EN
          if (dig_cout ^ dig_cmsb) begin
            sum_d = a_sign ? SatMin : SatMax;
          end
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8 with DIGIT=1 (index 0) and DIGIT=4 (index 1).
// Expected values honour SERIAL_ADDSUB_SAT_EN when it is defined.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] op_a      [2];
  logic [7:0] op_b      [2];
  logic       op_sub    [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] sum       [2];
  logic       carry_out [2];
  logic       overflow  [2];
  logic       busy      [2];

  int total = 0;
  int bad   = 0;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(op_a[0]), .b(op_b[0]), .sub(op_sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum[0]), .carry_out(carry_out[0]), .overflow(overflow[0]), .busy(busy[0])
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(op_a[1]), .b(op_b[1]), .sub(op_sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum[1]), .carry_out(carry_out[1]), .overflow(overflow[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                                output logic [7:0] s, output logic c, output logic o);
    logic [7:0] bb;
    logic [8:0] f;
    bb = sv ? ~bv : bv;
    f  = {1'b0, av} + {1'b0, bb} + {8'd0, sv};
    s  = f[7:0];
    c  = f[8];
    o  = (av[7] == bb[7]) && (f[7] != av[7]);
    if (SAT && o) s = av[7] ? 8'h80 : 8'h7F;
  endfunction

  // Accept one operation on DUT k, check latency and result, then drain it.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
    int n;
    int nd;
    nd = (k == 0) ? 8 : 2;
    @(negedge clk);
    total++;
    if (in_ready[k] !== 1'b1) begin
      bad++;
      $display("FAIL %s[%0d] in_ready before accept: got=%b want=1", nm, k, in_ready[k]);
    end
    in_valid[k] = 1'b1;
    op_a[k] = av;
    op_b[k] = bv;
    op_sub[k] = sv;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    op_a[k] = 8'hA5;
    op_b[k] = 8'h5A;
    op_sub[k] = ~sv;
    n = 0;
    while (out_valid[k] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n != nd) begin
      bad++;
      $display("FAIL %s[%0d] latency: got=%0d edges want=%0d", nm, k, n, nd);
    end
    total++;
    if (sum[k] !== es) begin
      bad++;
      $display("FAIL %s[%0d] sum: got=%h want=%h", nm, k, sum[k], es);
    end
    total++;
    if (carry_out[k] !== ec) begin
      bad++;
      $display("FAIL %s[%0d] carry_out: got=%b want=%b", nm, k, carry_out[k], ec);
    end
    total++;
    if (overflow[k] !== eo) begin
      bad++;
      $display("FAIL %s[%0d] overflow: got=%b want=%b", nm, k, overflow[k], eo);
    end
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    total++;
    if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
      bad++;
      $display("FAIL %s[%0d] handoff: got in_ready=%b out_valid=%b want 1/0", nm, k,
               in_ready[k], out_valid[k]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (sum[k] !== 8'h00 || carry_out[k] !== 1'b0 || overflow[k] !== 1'b0 ||
          busy[k] !== 1'b0 || in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: got sum=%h c=%b o=%b busy=%b rdy=%b vld=%b want 00/0/0/0/1/0",
                 k, sum[k], carry_out[k], overflow[k], busy[k], in_ready[k], out_valid[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    for (int k = 0; k < 2; k++) begin
      run_op(k, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
      run_op(k, 8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, "add_7f_01");
      run_op(k, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
      run_op(k, 8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, "sub_80_01");
      run_op(k, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "sub_00_00");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid[0] = 1'b1;
    op_a[0] = 8'h0F;
    op_b[0] = 8'h00;
    op_sub[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sum[0] !== 8'h00 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
        carry_out[0] !== 1'b0 || overflow[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got sum=%h busy=%b rdy=%b c=%b o=%b vld=%b want 00/0/1/0/0/0",
               sum[0], busy[0], in_ready[0], carry_out[0], overflow[0], out_valid[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    in_valid[1] = 1'b1;
    op_a[1] = 8'h10;
    op_b[1] = 8'h20;
    op_sub[1] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    n = 0;
    while (out_valid[1] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    in_valid[1] = 1'b1;
    op_a[1] = 8'h55;
    op_b[1] = 8'h11;
    repeat (5) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || sum[1] !== 8'h30) begin
        bad++;
        $display("FAIL hold: got vld=%b rdy=%b sum=%h want 1/0/30",
                 out_valid[1], in_ready[1], sum[1]);
      end
    end
    @(negedge clk);
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[1] = 1'b0;
    total++;
    if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0 || sum[1] !== 8'h30) begin
      bad++;
      $display("FAIL hold_idle: got rdy=%b busy=%b sum=%h want 1/0/30",
               in_ready[1], busy[1], sum[1]);
    end
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    total++;
    if (busy[1] !== 1'b1 || sum[1] !== 8'h00) begin
      bad++;
      $display("FAIL hold_accept: got busy=%b sum=%h want 1/00", busy[1], sum[1]);
    end
    n = 0;
    while (out_valid[1] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n != 2 || sum[1] !== 8'h66) begin
      bad++;
      $display("FAIL hold_second: got edges=%0d sum=%h want 2/66", n, sum[1]);
    end
    @(negedge clk);
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] av, bv, es;
    logic       sv, ec, eo;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        sv = 1'($urandom);
        model(av, bv, sv, es, ec, eo);
        run_op(k, av, bv, sv, es, ec, eo, "b2b");
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      op_a[k] = 8'h00;
      op_b[k] = 8'h00;
      op_sub[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    test_reset();
    test_vectors();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
